serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: diff = a - b, computed LSB-first, one full-subtractor bit per clock.
//   Pairs with the structural full adder as its subtract-direction counterpart.
//   Uses a single 1-bit datapath, trading latency for area.
//   Sits behind a start/done handshake, for use by multi-cycle arithmetic controllers.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//   clk      in   1      single clock, rising edge
//   rst_n    in   1      asynchronous reset, active-low
//   start    in   1      request; sampled only when ready=1
//   a        in   WIDTH  minuend, captured on accepted start
//   b        in   WIDTH  subtrahend, captured on accepted start
//   ready    out  1      high in IDLE; start is accepted only when high
//   busy     out  1      high in RUN
//   done     out  1      one-cycle pulse: diff/borrow valid
//   diff     out  WIDTH  a - b mod 2^WIDTH; held until next accepted start
//   borrow   out  1      final borrow out (1 when a < b unsigned); held with diff
// BEHAVIOUR
//   Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, borrow=0, bit counter=0, operand shift regs=0.
//   Reset assertion mid-operation aborts immediately to these values; no done is produced.
//   FSM states and transitions:
//     IDLE -> RUN   on start=1. Same edge: latch a,b into shift regs; clear borrow-in and counter.
//     RUN  -> RUN   while counter < WIDTH-1. Each edge processes bit i = counter:
//       d    = a_i ^ b_i ^ bin
//       bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
//       Shift d into the result MSB, shifting right. Shift the operands right. bin <= bout. counter++.
//     RUN  -> DONE  on the edge that processes bit WIDTH-1. Same edge: diff and borrow registers take their final values.
//     DONE -> IDLE  unconditionally on the next edge. done=1 only while in DONE.
//   Latency: start is sampled at edge E. done is high in the cycle after edge E+WIDTH, exactly one cycle wide.
//     Next start is accepted at edge E+WIDTH+2 at the earliest.
//   start while busy or done: ignored, with no queuing. a and b may change freely after acceptance.
//   diff/borrow update only on the RUN->DONE edge. During RUN they keep the previous result.
//     The internal result shift reg is separate from the diff output.
//   All arithmetic is modulo 2^WIDTH. Operands are interpreted both as unsigned (borrow) and as signed (overflow).
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     Adds port `ovf  out  1` giving signed overflow: ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
//     Registered and updated together with diff; reset value 0; held until the next result.
//   SERIAL_SUB_OVF_EN undefined:
//     No ovf port and no sign-tracking logic. All other behaviour is identical.
// TESTING (WIDTH=8)
//   Reset: rst_n=0 -> ready=1, busy=0, done=0, diff=0x00, borrow=0. Release, 20 idle cycles -> outputs unchanged.
//   a=0x05, b=0x03, start pulse at edge E -> busy for 8 cycles; done high in the cycle after edge E+8 only;
//     diff=0x02, borrow=0, ovf=0.
//   a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0. Then a=0x00, b=0x00 -> diff=0x00, borrow=0.
//   a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1 (macro defined). a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
//   Hold start=1 with changing a/b throughout RUN -> exactly one result, from the operands latched at acceptance.
//     The back-to-back op is accepted only after returning to IDLE.
//   rst_n=0 at RUN bit 4 -> no done pulse; all outputs return to reset values.
//     A new op after release computes correctly: 0xFF-0x01=0xFE.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// Optional signed-overflow flag is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  // Requester side: issues operands and start, observes status and result
  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  ready, busy, done, diff, borrow
  );

  // Subtractor side
  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output ready, busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// start is accepted only in IDLE; done pulses for one cycle WIDTH+1 cycles after acceptance.
// Optional feature: define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 low result bits; the final bit goes straight into diff
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_bit, b_bit, d_bit, bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             ovf_next;
`endif

  // One full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    a_bit     = a_q[0];
    b_bit     = b_q[0];
    d_bit     = a_bit ^ b_bit ^ bin_q;
    bout      = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
    res_shift = {d_bit, res_q};
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last bit the operand LSBs are the sign bits and d_bit is the result sign
  always_comb begin
    ovf_next = (a_bit ^ b_bit) & (d_bit ^ a_bit);
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_d     = bus.a;
          b_d     = bus.b;
          bin_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift[WIDTH-1:1];
        bin_d = bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d  = StDone;
          cnt_d    = '0;
          diff_d   = res_shift;
          borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = ovf_next;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Status decode and registered result outputs
  always_comb begin
    bus.ready  = (state_q == StIdle);
    bus.busy   = (state_q == StRun);
    bus.done   = (state_q == StDone);
    bus.diff   = diff_q;
    bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    bus.ovf    = ovf_q;
`endif
  end

endmodule
